// File: rtl/fir_pkg.sv
// Shared constants, types and helpers for the FIR output conditioning stage.
package fir_pkg;

    localparam int FIR_OUT_LAT     = 2;
    localparam int FIR_OUTBITS_DEF = 16;

    // Accumulator width needed to sum TAPS products of MULTBITS bits without overflow.
    function automatic int accubits(input int taps, input int multbits);
        return multbits + $clog2(taps);
    endfunction

    // Default-width FIFO entry; the stage declares its own copy sized by OUTBITS.
    typedef struct packed {
        logic                              sat;
        logic signed [FIR_OUTBITS_DEF-1:0] data;
    } fir_out_entry_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Generic synchronous FIFO with async active-high reset and wrap-bit pointers.
module fir_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count = CW'(wr_ptr_q - rd_ptr_q);
        rd_ok = rd_en && !empty;
        // A write into a full FIFO is legal when the head is leaving in the same cycle.
        wr_ok = wr_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_output_stage.sv
// FIR output stage: round, shift, saturate (FIR_OUT_SAT_EN) or wrap, then FIFO to a stream.
// Without FIR_OUT_SAT_EN the rounded value wraps to OUTBITS and out_sat is always 0.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int TAPS       = 401,
    parameter int MULTBITS   = 32,
    parameter int OUTBITS    = 16,
    parameter int FRAC_SHIFT = 15,
    parameter int FIFO_DEPTH = 8,
    localparam int ACCUBITS  = accubits(TAPS, MULTBITS),
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [ACCUBITS-1:0] acc_in,
    input  logic                       acc_valid,
    output logic signed [OUTBITS-1:0]  out_data,
    output logic                       out_sat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    input  logic                       clear_ovf,
    output logic [CW-1:0]              fill_level
);

    typedef struct packed {
        logic                      sat;
        logic signed [OUTBITS-1:0] data;
    } out_entry_t;

    // Evaluates to 2^(FRAC_SHIFT-1), or 0 when no shift is applied.
    localparam logic [ACCUBITS:0] ROUND_HALF = ({{ACCUBITS{1'b0}}, 1'b1} << FRAC_SHIFT) >> 1;

    logic signed [ACCUBITS:0] acc_ext;
    logic signed [ACCUBITS:0] rounded;
    logic signed [ACCUBITS:0] s1_data_q, s1_data_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     ovf_q, ovf_d;

    out_entry_t               wr_entry;
    out_entry_t               rd_entry;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_wr;
    logic                     fifo_rd;
    logic                     drop;

    always_comb begin
        acc_ext    = {acc_in[ACCUBITS-1], acc_in};
        rounded    = (acc_ext + $signed(ROUND_HALF)) >>> FRAC_SHIFT;
        s1_valid_d = acc_valid;
        s1_data_d  = acc_valid ? rounded : s1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

`ifdef FIR_OUT_SAT_EN
    logic [ACCUBITS-OUTBITS+1:0] upper;
    logic                        in_range;

    // The value fits when every bit from the output sign bit upward agrees.
    always_comb begin
        upper    = s1_data_q[ACCUBITS:OUTBITS-1];
        in_range = (&upper) || !(|upper);
        if (in_range) begin
            wr_entry.sat  = 1'b0;
            wr_entry.data = s1_data_q[OUTBITS-1:0];
        end else if (s1_data_q[ACCUBITS]) begin
            wr_entry.sat  = 1'b1;
            wr_entry.data = {1'b1, {(OUTBITS - 1){1'b0}}};
        end else begin
            wr_entry.sat  = 1'b1;
            wr_entry.data = {1'b0, {(OUTBITS - 1){1'b1}}};
        end
    end
`else
    logic unused_upper;

    always_comb begin
        unused_upper  = ^s1_data_q[ACCUBITS:OUTBITS];
        wr_entry.sat  = 1'b0;
        wr_entry.data = s1_data_q[OUTBITS-1:0];
    end
`endif

    always_comb begin
        fifo_rd = out_ready && !fifo_empty;
        fifo_wr = s1_valid_q && (!fifo_full || fifo_rd);
        drop    = s1_valid_q && fifo_full && !fifo_rd;
        ovf_d   = ovf_q;
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH ($bits(out_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill_level)
    );

    always_comb begin
        out_data  = rd_entry.data;
        out_sat   = rd_entry.sat;
        out_valid = !fifo_empty;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed self-checking bench for fir_output_stage at default parameters.
module tb_fir_output_stage;
    import fir_pkg::*;

    localparam int AB = accubits(401, 32);

    logic                 clk;
    logic                 rst;
    logic signed [AB-1:0] acc_in;
    logic                 acc_valid;
    logic signed [15:0]   out_data;
    logic                 out_sat;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overflow;
    logic                 clear_ovf;
    logic [3:0]           fill_level;

    int checks = 0;
    int errors = 0;

    fir_output_stage dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_one(input string tag, input longint acc, input longint exp_data,
                            input longint exp_sat);
        acc_in    = AB'(acc);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        repeat (FIR_OUT_LAT - 1) tick();
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_data"}, longint'(out_data), exp_data);
        chk({tag, "_sat"}, longint'(out_sat), exp_sat);
        tick();
    endtask

    longint rvec [4];
    longint rexp [4];

    initial begin
        rst       = 1'b1;
        acc_in    = '0;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        rvec = '{16384, 16383, -16384, -16385};
        rexp = '{1, 0, 0, -1};
        tick();
        tick();
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_fill", longint'(fill_level), 0);
        chk("rst_ovf", longint'(overflow), 0);
        chk("rst_data", longint'(out_data), 0);
        chk("rst_sat", longint'(out_sat), 0);
        rst = 1'b0;
        tick();

        // Rounding stream, head sample checked each cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                acc_in    = AB'(rvec[k]);
                acc_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
            end
            tick();
            if (k == 0) begin
                chk("lat_not_yet", longint'(out_valid), 0);
            end else if (k <= 4) begin
                chk($sformatf("rnd%0d_valid", k - 1), longint'(out_valid), 1);
                chk($sformatf("rnd%0d_data", k - 1), longint'(out_data), rexp[k-1]);
                chk($sformatf("rnd%0d_sat", k - 1), longint'(out_sat), 0);
            end else begin
                chk("rnd_empty", longint'(out_valid), 0);
            end
        end

`ifdef FIR_OUT_SAT_EN
        send_one("sat_pos", 64'sd2147483648, 32767, 1);
        send_one("sat_neg", -64'sd2147483648, -32768, 1);
        send_one("edge_in", 64'sd1073709056, 32767, 0);
        send_one("edge_rnd", 64'sd1073725440, 32767, 1);
`else
        send_one("wrap_pos", 64'sd2147483648, 0, 0);
        send_one("wrap_neg", -64'sd2147483648, 0, 0);
        send_one("edge_in", 64'sd1073709056, 32767, 0);
        send_one("edge_rnd", 64'sd1073725440, -32768, 0);
`endif

        // Overflow: 10 samples into an 8-deep FIFO with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            acc_in    = AB'(longint'(i) * 32768);
            acc_valid = 1'b1;
            tick();
        end
        acc_valid = 1'b0;
        tick();
        tick();
        chk("ovf_fill", longint'(fill_level), 8);
        chk("ovf_flag", longint'(overflow), 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain%0d_valid", k), longint'(out_valid), 1);
            chk($sformatf("drain%0d_data", k), longint'(out_data), k);
            tick();
        end
        chk("drain_empty", longint'(out_valid), 0);
        chk("ovf_sticky", longint'(overflow), 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_clear", longint'(overflow), 0);

        // Full FIFO with simultaneous read and write every cycle.
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            acc_in    = AB'(longint'(i) * 32768);
            acc_valid = 1'b1;
            tick();
        end
        chk("rw_prefill", longint'(fill_level), 8);
        out_ready = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            acc_in = AB'(longint'(t + 9) * 32768);
            tick();
            chk($sformatf("rw%0d_fill", t), longint'(fill_level), 8);
            chk($sformatf("rw%0d_ovf", t), longint'(overflow), 0);
            chk($sformatf("rw%0d_data", t), longint'(out_data), t + 1);
        end
        acc_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset mid-stream: 5 held, one in stage 1, one at the input.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            acc_in    = AB'(longint'(i) * 32768);
            acc_valid = 1'b1;
            tick();
        end
        acc_in = AB'(longint'(7) * 32768);
        chk("mid_fill", longint'(fill_level), 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_fill", longint'(fill_level), 0);
        chk("mid_rst_data", longint'(out_data), 0);
        acc_valid = 1'b0;
        tick();
        rst = 1'b0;
        acc_in    = AB'(longint'(100) * 32768);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        chk("post_lat", longint'(out_valid), 0);
        tick();
        chk("post_valid", longint'(out_valid), 1);
        chk("post_data", longint'(out_data), 100);
        chk("post_fill", longint'(fill_level), 1);
        tick();
        chk("post_sole", longint'(fill_level), 1);
        out_ready = 1'b1;
        tick();
        chk("post_empty", longint'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_output_stage.md
# fir_output_stage

Output conditioning stage directly downstream of the FIR binary-tree accumulator. Takes one full-precision signed sum per `acc_valid`, rounds and right-shifts it to the output scale, saturates it to `OUTBITS`, and buffers results in a small FIFO behind a valid/ready stream. The accumulator cannot stall, so this block never back-pressures its input. Samples arriving while the FIFO is full are dropped and flagged.

## Interface
- `TAPS`, 401: filter length; used only to derive `ACCUBITS`.
- `MULTBITS`, 32: product width; `ACCUBITS = MULTBITS + $clog2(TAPS)` (41 at defaults).
- `OUTBITS`, 16: signed output width, 2..`ACCUBITS`.
- `FRAC_SHIFT`, 15: right-shift applied after rounding, 0..`ACCUBITS-2`.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `acc_in` in `ACCUBITS`: signed two's-complement accumulator sum.
- `acc_valid` in 1: `acc_in` is valid this cycle; always accepted.
- `out_data` out `OUTBITS`: signed output sample at the FIFO head.
- `out_sat` out 1: head sample was clipped; qualified by `out_valid`.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head sample when `out_valid && out_ready`.
- `overflow` out 1: sticky; at least one sample was dropped.
- `clear_ovf` in 1: clears `overflow`.
- `fill_level` out `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.

## Operation
- **Stage 1, round.**
  - Sign-extend `acc_in` to `ACCUBITS+1` bits.
  - Add `2^(FRAC_SHIFT-1)` when `FRAC_SHIFT>0`; this is round-half-up, toward +∞.
  - Arithmetic-shift right by `FRAC_SHIFT`.
  - Register the result with a valid bit.
- **Stage 2, saturate.**
  - Result > `2^(OUTBITS-1)-1` → max, `sat=1`.
  - Result < `-2^(OUTBITS-1)` → min, `sat=1`.
  - Otherwise take the low `OUTBITS` bits, `sat=0`.
  - Push `{sat, data}` into the FIFO.
- **FIFO.**
  - Write when the stage-2 valid bit is set and the FIFO is not full.
  - Read on `out_valid && out_ready`.
- **Full plus write, no read.** The sample is dropped, `overflow` sets, and `fill_level` stays `FIFO_DEPTH`.
- **Full plus write plus read in the same cycle.** Both happen and no drop occurs.
- **Empty plus write.** No bypass; `out_valid` rises the cycle after the write.
- **`clear_ovf` and a new drop in the same cycle.** `overflow` ends at 1; set wins.
- **`out_ready` while empty.** Ignored.
- **Pointers.** Wrap modulo `FIFO_DEPTH`, with an extra wrap bit to distinguish full from empty.
- **Reset, including mid-stream.**
  - Pipeline valid bits, pointers, `overflow` and `fill_level` all go to 0 immediately.
  - `out_valid`, `out_sat` and `overflow` are 0 while `rst` is high.
  - `out_data` is 0; the storage array needs no reset, but the output mux is forced to 0 while empty.
  - In-flight samples are discarded.

## Timing
- `acc_valid` in cycle N → FIFO written at the edge closing cycle N+1 → `out_valid` high in cycle N+2 when the FIFO was empty.
- Latency is 2 cycles.
- Throughput is one sample per cycle in, one per cycle out.
- `out_data`, `out_sat` and `out_valid` come from registers or the FIFO array only; there is no combinational path from `out_ready`.
- `fill_level` updates at the same edge as the write or read.

## Configuration
- **`FIR_OUT_SAT_EN` defined:** saturation as above.
- **`FIR_OUT_SAT_EN` undefined:**
  - Stage 2 takes the low `OUTBITS` bits of the rounded value, wrapping.
  - `out_sat` is tied to 0.
  - Latency stays 2 cycles.

## Structure
- Package `fir_pkg` holds:
  - the `accubits(taps, multbits)` function;
  - the `fir_out_entry_t` struct `{logic sat; logic signed [OUTBITS-1:0] data;}`, parameterized through the module;
  - the `FIR_OUT_LAT = 2` constant.
- Sub-module `fir_sync_fifo` is a generic width/depth synchronous FIFO with async active-high reset.
  - Ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty` and `count`.
  - This block instantiates it once.

## Test plan
All scenarios use defaults (`OUTBITS=16`, `FRAC_SHIFT=15`).
1. **Rounding.** `acc_in` = 16384, 16383, −16384, −16385 → `out_data` 1, 0, 0, −1, all with `out_sat=0`, each appearing 2 cycles after input with `out_ready=1`.
2. **Saturation, macro on.** `acc_in` = 2^31 → 32767 with `out_sat=1`; `acc_in` = −2^31 → −32768 with `out_sat=1`.
3. **Wrap, macro off.** `acc_in` = 2^31 → `out_data=0`, `out_sat=0`.
4. **Overflow.**
   - Hold `out_ready=0` and send 10 consecutive valids.
   - `fill_level=8`, `overflow=1`, samples 9–10 are lost.
   - Draining yields exactly samples 1–8 in order.
   - Pulse `clear_ovf` → `overflow=0`.
5. **Simultaneous read and write.**
   - Hold the FIFO full, then stream `acc_valid` and `out_ready` both at 1 for 20 cycles.
   - No drops, `overflow` stays 0, `fill_level` stays 8.
6. **Reset mid-stream.**
   - Assert `rst` with 5 entries held and one sample in each pipeline stage.
   - `out_valid=0` and `fill_level=0` immediately.
   - After release, the next input emerges 2 cycles later as the sole entry.
